// File: rtl/pll_spi_pkg.sv
// Shared types and constants for the PLL SPI engine arbiter.
// Engine command widths, FSM state encoding and default watchdog limit.
package pll_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ACK   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 100000;

endpackage

// File: rtl/pll_spi_arbiter_if.sv
// Requester and SPI byte engine signal bundle for pll_spi_arbiter.
// master = arbiter side, slave = requesters plus engine side.
interface pll_spi_arbiter_if
    import pll_spi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int GRANT_W = 3
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   if_read;
    logic                   if_write;
    logic [ADDR_W-1:0]      if_addr;
    logic [DATA_W-1:0]      if_wdata;
    logic                   if_reset;
    logic [DATA_W-1:0]      if_rdata;
    logic                   if_done;
    logic                   busy;
    logic [GRANT_W-1:0]     grant_id;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_lock,
        input  if_rdata, if_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output if_read, if_write, if_addr, if_wdata, if_reset,
        output busy, grant_id
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_lock,
        output if_rdata, if_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  if_read, if_write, if_addr, if_wdata, if_reset,
        input  busy, grant_id
    );

endinterface

// File: rtl/pll_spi_rr_pick.sv
// Combinational round-robin picker: first eligible requester after i_last.
// Eligibility is the request vector gated by the lock mask.
module pll_spi_rr_pick #(
    parameter int NREQ    = 2,
    parameter int GRANT_W = 3
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [GRANT_W-1:0] i_last,
    input  logic [NREQ-1:0]    i_mask,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_found
);

    logic [NREQ-1:0] w_elig;
    int              w_last;
    int              w_best;

    assign w_elig = i_req & i_mask;
    assign w_last = int'(i_last) % NREQ;

    // Distance 0 is the requester right after the last grant.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_best  = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (w_elig[j] &&
                ((j - w_last - 1 + NREQ) % NREQ) < w_best) begin
                w_best  = (j - w_last - 1 + NREQ) % NREQ;
                o_idx   = GRANT_W'(j);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_spi_arbiter.sv
// Shares one PLL SPI byte engine between NREQ requesters, round-robin,
// with per-requester lock and a launch-to-done watchdog.
module pll_spi_arbiter
    import pll_spi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GRANT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    pll_spi_arbiter_if.master   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t              r_state, w_state;
    logic                r_if_read, w_if_read;
    logic                r_if_write, w_if_write;
    logic [ADDR_W-1:0]   r_if_addr, w_if_addr;
    logic [DATA_W-1:0]   r_if_wdata, w_if_wdata;
    logic                r_if_reset, w_if_reset;
    logic [NREQ-1:0]     r_req_ready, w_req_ready;
    logic [NREQ-1:0]     r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic                r_rsp_err, w_rsp_err;
    logic                r_busy;
    logic [GRANT_W-1:0]  r_grant, w_grant;
    logic                r_lock_act, w_lock_act;
    logic [GRANT_W-1:0]  r_lock_owner, w_lock_owner;
    logic [CNT_W-1:0]    r_cnt, w_cnt;

    logic [NREQ-1:0]     w_mask;
    logic [GRANT_W-1:0]  w_pick;
    logic                w_found;
    logic [NREQ-1:0]     w_pick_oh;
    logic [NREQ-1:0]     w_grant_oh;
    logic                w_fin;
    logic                w_to;

    assign w_mask     = r_lock_act ? (NREQ'(1) << r_lock_owner)
                                   : {NREQ{1'b1}};
    assign w_pick_oh  = NREQ'(1) << w_pick;
    assign w_grant_oh = NREQ'(1) << r_grant;

    pll_spi_rr_pick #(
        .NREQ    (NREQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_grant),
        .i_mask  (w_mask),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_state      = r_state;
        w_if_read    = r_if_read;
        w_if_write   = r_if_write;
        w_if_addr    = r_if_addr;
        w_if_wdata   = r_if_wdata;
        w_if_reset   = r_if_reset;
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_rsp_rdata  = r_rsp_rdata;
        w_rsp_err    = r_rsp_err;
        w_grant      = r_grant;
        w_lock_act   = r_lock_act;
        w_lock_owner = r_lock_owner;
        w_cnt        = r_cnt;
        w_fin        = 1'b0;
        w_to         = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_if_reset = 1'b1;
                w_if_read  = 1'b0;
                w_if_write = 1'b0;
                if (w_found) begin
                    w_grant     = w_pick;
                    w_if_write  = |(bus.req_write & w_pick_oh);
                    w_if_read   = ~|(bus.req_write & w_pick_oh);
                    w_if_addr   = ADDR_W'(bus.req_addr >>
                                          (ADDR_W * int'(w_pick)));
                    w_if_wdata  = DATA_W'(bus.req_wdata >>
                                          (DATA_W * int'(w_pick)));
                    w_req_ready = w_pick_oh;
                    w_state     = SETUP;
                end
            end
            SETUP: begin
                w_if_reset = 1'b0;
                w_cnt      = '0;
                w_state    = ACK;
            end
            ACK: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) w_to = 1'b1;
                else if (!bus.if_done) w_state = WAIT;
            end
            WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (bus.if_done) w_fin = 1'b1;
                else if (r_cnt == LAST_CNT) w_to = 1'b1;
            end
            default: w_state = IDLE;
        endcase
        // Completion and watchdog abort share one exit path.
        if (w_fin || w_to) begin
            w_rsp_valid  = w_grant_oh;
            w_rsp_rdata  = w_to ? '0 : bus.if_rdata;
            w_rsp_err    = w_to;
            w_if_reset   = 1'b1;
            w_if_read    = 1'b0;
            w_if_write   = 1'b0;
            w_lock_act   = |(bus.req_lock & w_grant_oh);
            w_lock_owner = r_grant;
            w_state      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_if_read    <= 1'b0;
            r_if_write   <= 1'b0;
            r_if_addr    <= '0;
            r_if_wdata   <= '0;
            r_if_reset   <= 1'b1;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_grant      <= GRANT_W'(NREQ - 1);
            r_lock_act   <= 1'b0;
            r_lock_owner <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_if_read    <= w_if_read;
            r_if_write   <= w_if_write;
            r_if_addr    <= w_if_addr;
            r_if_wdata   <= w_if_wdata;
            r_if_reset   <= w_if_reset;
            r_req_ready  <= w_req_ready;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_rdata  <= w_rsp_rdata;
            r_rsp_err    <= w_rsp_err;
            r_busy       <= (w_state != IDLE);
            r_grant      <= w_grant;
            r_lock_act   <= w_lock_act;
            r_lock_owner <= w_lock_owner;
            r_cnt        <= w_cnt;
        end
    end

    assign bus.if_read   = r_if_read;
    assign bus.if_write  = r_if_write;
    assign bus.if_addr   = r_if_addr;
    assign bus.if_wdata  = r_if_wdata;
    assign bus.if_reset  = r_if_reset;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant;

endmodule

// File: tb/tb_pll_spi_arbiter.sv
// Scoreboard bench for pll_spi_arbiter: requester drivers, an SPI engine
// model, a transaction-level arbitration model and a decoupled monitor.
module tb_pll_spi_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 50;
    localparam int GRANT_W = 3;

    typedef struct {
        bit         wr;
        bit         lk;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        int         id;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } lex_t;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        bit         err;
    } rex_t;

    logic clk;
    logic reset;

    pll_spi_arbiter_if #(.NREQ(NREQ), .GRANT_W(GRANT_W)) bus ();

    pll_spi_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .GRANT_W (GRANT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cmd_t q_cmd[NREQ][$];
    cmd_t stage[NREQ][$];
    lex_t exp_l[$];
    rex_t exp_r[$];

    int checks = 0;
    int errors = 0;
    int m_last = NREQ - 1;
    bit m_lock = 0;
    int m_owner = 0;
    bit m_dead = 0;
    bit eng_dead = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic add(int r, bit wr, bit lk, logic [7:0] a, logic [7:0] d);
        cmd_t c;
        c.wr = wr; c.lk = lk; c.addr = a; c.wdata = d;
        stage[r].push_back(c);
    endtask

    // Transaction-level arbitration: round-robin over requesters that still
    // have commands, restricted to the lock owner while a lock is held.
    task automatic plan(input bit abort_rsp);
        int   g;
        bit   any;
        cmd_t c;
        lex_t le;
        rex_t re;
        while (1) begin
            any = 0;
            for (int i = 0; i < NREQ; i++)
                if (stage[i].size() > 0) any = 1;
            if (!any) break;
            g = -1;
            if (m_lock) g = m_owner;
            else
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && stage[(m_last + k) % NREQ].size() > 0)
                        g = (m_last + k) % NREQ;
            c = stage[g].pop_front();
            q_cmd[g].push_back(c);
            le.id = g; le.wr = c.wr; le.addr = c.addr; le.wdata = c.wdata;
            exp_l.push_back(le);
            re.id    = g;
            re.err   = m_dead;
            re.rdata = m_dead ? 8'h00 : (c.wr ? c.wdata : (c.addr ^ 8'hA7));
            if (!abort_rsp) exp_r.push_back(re);
            m_last  = g;
            m_lock  = c.lk;
            m_owner = g;
        end
    endtask

    function automatic bit all_idle();
        bit ok;
        ok = (bus.req_valid == '0) && (exp_r.size() == 0) && !bus.busy;
        for (int i = 0; i < NREQ; i++)
            if (q_cmd[i].size() > 0) ok = 0;
        return ok;
    endfunction

    task automatic wait_done(string nm, int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!all_idle() && n < budget);
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, %0d rsp pending",
                     nm, n, exp_r.size());
            exp_r.delete();
            exp_l.delete();
            for (int i = 0; i < NREQ; i++) q_cmd[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(string t);
        chk({t, "_if_reset"}, bus.if_reset, 1);
        chk({t, "_if_read"}, bus.if_read, 0);
        chk({t, "_if_write"}, bus.if_write, 0);
        chk({t, "_if_addr"}, bus.if_addr, 0);
        chk({t, "_if_wdata"}, bus.if_wdata, 0);
        chk({t, "_req_ready"}, bus.req_ready, 0);
        chk({t, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({t, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({t, "_rsp_err"}, bus.rsp_err, 0);
        chk({t, "_busy"}, bus.busy, 0);
        chk({t, "_grant_id"}, bus.grant_id, NREQ - 1);
    endtask

    // Requesters: hold each command until its ready pulse; keep req_lock of
    // the in-flight command until its response, then expose the next one.
    initial begin
        cmd_t c;
        bit   infl[NREQ];
        bit   cur_lk[NREQ];
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            infl[i] = 0;
            cur_lk[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (reset) infl[i] = 0;
                if (bus.rsp_valid[i]) begin
                    infl[i] = 0;
                    bus.req_lock[i] = bus.req_valid[i] ? cur_lk[i] : 1'b0;
                end
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    infl[i] = 1;
                    bus.req_valid[i] = 1'b0;
                end
                if (!bus.req_valid[i] && q_cmd[i].size() > 0) begin
                    c = q_cmd[i].pop_front();
                    bus.req_valid[i] = 1'b1;
                    bus.req_write[i] = c.wr;
                    bus.req_addr[i*8 +: 8] = c.addr;
                    bus.req_wdata[i*8 +: 8] = c.wdata;
                    cur_lk[i] = c.lk;
                    if (!infl[i]) bus.req_lock[i] = c.lk;
                end
            end
        end
    end

    // SPI engine: busy (done low) a few cycles after launch, then done high
    // with read data addr^0xA7 or the write data echoed back.
    initial begin
        int st, cnt, d1, d2;
        st = 0; cnt = 0; d1 = 1; d2 = 1;
        bus.if_done  = 1'b1;
        bus.if_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset || bus.if_reset) begin
                st = 0;
                bus.if_done = 1'b1;
            end else begin
                case (st)
                    0: begin
                        st = 1; cnt = 0;
                        d1 = int'($urandom_range(1, 3));
                    end
                    1: begin
                        cnt++;
                        if (cnt >= d1) begin
                            bus.if_done = 1'b0;
                            st = 2; cnt = 0;
                            d2 = int'($urandom_range(1, 8));
                        end
                    end
                    2: if (!eng_dead) begin
                        cnt++;
                        if (cnt >= d2) begin
                            bus.if_done  = 1'b1;
                            bus.if_rdata = bus.if_write ? bus.if_wdata
                                                        : (bus.if_addr ^ 8'hA7);
                            st = 3;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT accepts or responds.
    initial begin
        int   cyc, start;
        bit   prev;
        lex_t e;
        rex_t r;
        cyc = 0; start = 0; prev = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (bus.req_ready != '0) begin
                    if (exp_l.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL launch: unexpected req_ready=%b",
                                 bus.req_ready);
                    end else begin
                        e = exp_l.pop_front();
                        chk("ready_id", bus.req_ready, 32'(1) << e.id);
                        chk("grant_id", bus.grant_id, e.id);
                        chk("if_write", bus.if_write, e.wr);
                        chk("if_read", bus.if_read, !e.wr);
                        chk("if_addr", bus.if_addr, e.addr);
                        chk("if_wdata", bus.if_wdata, e.wdata);
                        chk("setup_if_reset", bus.if_reset, 1);
                        chk("setup_busy", bus.busy, 1);
                    end
                end
                if (!bus.if_reset && prev) start = cyc;
                if (bus.rsp_valid != '0) begin
                    if (exp_r.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp: unexpected rsp_valid=%b",
                                 bus.rsp_valid);
                    end else begin
                        r = exp_r.pop_front();
                        chk("rsp_id", bus.rsp_valid, 32'(1) << r.id);
                        chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                        chk("rsp_err", bus.rsp_err, r.err);
                        chk("rsp_if_reset", bus.if_reset, 1);
                        if (r.err) chk("timeout_lat", cyc - start, TIMEOUT);
                    end
                end
            end
            prev = bus.if_reset;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
        @(negedge clk);

        add(0, 1, 0, 8'h43, 8'h01);
        plan(0);
        wait_done("single_write", 100);

        add(1, 0, 0, 8'h02, 8'h00);
        plan(0);
        wait_done("read", 100);

        add(0, 1, 0, 8'h10, 8'h11);
        add(0, 1, 0, 8'h12, 8'h13);
        add(1, 0, 0, 8'h20, 8'h00);
        add(1, 1, 0, 8'h21, 8'h22);
        plan(0);
        wait_done("contention", 300);

        for (int j = 0; j < 4; j++)
            add(0, 1, (j < 3), 8'h30 + 8'(j), 8'h40 + 8'(j));
        add(1, 1, 0, 8'h50, 8'h51);
        plan(0);
        wait_done("lock", 400);

        eng_dead = 1; m_dead = 1;
        add(0, 1, 0, 8'h60, 8'h61);
        plan(0);
        wait_done("timeout", 200);
        eng_dead = 0; m_dead = 0;
        add(0, 0, 0, 8'h33, 8'h00);
        plan(0);
        wait_done("after_timeout", 100);

        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                cnt = int'($urandom_range(0, 3));
                for (int j = 0; j < cnt; j++)
                    add(r, 1'($urandom), (j < cnt - 1) ? 1'($urandom) : 1'b0,
                        8'($urandom), 8'($urandom));
            end
            plan(0);
            wait_done("random", 400);
        end

        eng_dead = 1;
        add(1, 1, 0, 8'h55, 8'h66);
        plan(1);
        n = 0;
        while (bus.if_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midwait_reached", bus.if_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("midwait");
        reset = 1'b0;
        eng_dead = 0;
        m_last = NREQ - 1; m_lock = 0;
        repeat (3) @(negedge clk);

        add(1, 1, 0, 8'h77, 8'h78);
        add(0, 0, 0, 8'h79, 8'h00);
        plan(0);
        wait_done("post_reset", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
